// File: rtl/modn_down_timer_if.sv
// Control/status bundle for modn_down_timer.
//   master : drives en, load, load_val, start, stop, auto_reload; observes status
//   slave  : the timer; observes controls, drives count, tc, busy, done
interface modn_down_timer_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output en, load, load_val, start, stop, auto_reload,
    input  count, tc, busy, done
  );

  modport slave (
    input  en, load, load_val, start, stop, auto_reload,
    output count, tc, busy, done
  );
endinterface

// File: rtl/modn_down_timer.sv
// Programmable modulo-N down counter/timer. Counts a loaded value down to 0,
// pulses tc for one cycle at terminal count, then reloads (periodic) or
// parks in DONE (one-shot).
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   tif    : slave side of modn_down_timer_if (controls in, count/tc/busy/done out)
//
// state | meaning
// IDLE  | stopped, count held, en ignored
// RUN   | decrementing on en=1 cycles
// DONE  | one-shot expired, count held at 0
module modn_down_timer #(
  parameter int WIDTH = 4,
  parameter int N     = 15
) (
  input  logic               clk,
  input  logic               resetn,
  modn_down_timer_if.slave   tif
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             busy_q;
  logic             done_q;

  // busy/done are updated alongside state so they stay registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      count_q  <= RST_VAL;
      reload_q <= RST_VAL;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (tif.load) begin
        count_q  <= tif.load_val;
        reload_q <= tif.load_val;
        state    <= RUN;
        busy_q   <= 1'b1;
        done_q   <= 1'b0;
      end else if (tif.start) begin
        count_q <= reload_q;
        state   <= RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (tif.stop) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else if (state == RUN && tif.en) begin
        if (count_q != '0) begin
          count_q <= count_q - WIDTH'(1);
        end else begin
          // Terminal edge: auto_reload is sampled only here.
          tc_q <= 1'b1;
          if (tif.auto_reload) begin
            count_q <= reload_q;
          end else begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end
    end
  end

  assign tif.count = count_q;
  assign tif.tc    = tc_q;
  assign tif.busy  = busy_q;
  assign tif.done  = done_q;

endmodule

// File: doc/modn_down_timer.md
Name: modn_down_timer

Overview:
- Programmable modulo-N down counter/timer: counts a loaded value down to 0, flags terminal count, then either auto-reloads or stops.
- Counterpart to the team's mod-N up counter, for timeouts, baud/tick dividers and delay generation.
- Single clock domain; all outputs registered.

Parameters:
- WIDTH, 4, bit-width of count and load value.
- N, 15, reset value of count and of the reload register; must satisfy 0 <= N <= 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- en  input  1  count enable; decrement happens only in cycles with en=1.
- load  input  1  one-cycle strobe: load load_val into count and reload register, enter RUN.
- load_val  input  WIDTH  value captured on load.
- start  input  1  one-cycle strobe: copy reload register into count, enter RUN.
- stop  input  1  one-cycle strobe: abort to IDLE, count held.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at terminal count.
- count  output  WIDTH  current count value.
- tc  output  1  terminal-count pulse, one cycle.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot expired).

Behaviour:
- Reset (async, resetn=0): count=N, reload_reg=N, state=IDLE, tc=0, busy=0, done=0.
- States are IDLE, RUN and DONE. busy=(state==RUN); done=(state==DONE); both registered with the state.
- Command priority per edge: load > start > stop > counting.
- load (any state): count<=load_val, reload_reg<=load_val, state<=RUN, tc<=0.
- start (any state, no load): count<=reload_reg, state<=RUN, tc<=0.
- stop (no load/start): state<=IDLE, count holds, tc<=0.
- RUN, en=1, count!=0: count<=count-1, tc<=0.
- RUN, en=1, count==0, auto_reload=1: count<=reload_reg, stay RUN, tc<=1.
- RUN, en=1, count==0, auto_reload=0: count stays 0, state<=DONE, tc<=1.
- RUN, en=0: count holds, tc<=0.
- IDLE/DONE without a command: count holds, tc<=0, en ignored.
- tc is high for exactly the one cycle following the terminal edge. It never stays high two consecutive cycles unless the reload value is 0 in periodic mode; then tc is high every enabled cycle.
- Period in auto-reload mode: reload value V gives tc once every V+1 enabled cycles, i.e. a mod-(V+1) down count V..0.
- Loading 0 in one-shot mode: tc and done assert after the first enabled edge.
- Arithmetic is unsigned, WIDTH bits. No underflow is possible, since 0 is never decremented.
- A command coincident with the terminal edge suppresses tc and the reload/DONE transition.
- Reset mid-count returns to the reset values immediately, independent of clk.

Test Plan:
- Reset: resetn=0 with clk running, then release -> count=15, tc=0, busy=0, done=0; count stays 15 with en=1 (IDLE).
- One-shot: load_val=3, auto_reload=0, en=1 constant -> count 3,2,1,0; tc high exactly one cycle after the count=0 edge; then done=1, busy=0, count held at 0 for 10 cycles.
- Periodic: load_val=4, auto_reload=1, en=1 -> count cycles 4,3,2,1,0,4...; tc period exactly 5 cycles over 4 periods. Then load_val=0 -> tc high every cycle.
- Enable gating: load_val=5, en toggled 1,0,0,1,... -> count decrements only on en=1 cycles; total enabled cycles to tc = 6.
- Priority/collision: assert load (load_val=7) on the same edge as count=0, en=1 -> count=7, tc stays 0. Assert stop with start -> start wins (RUN). Apply stop alone mid-count at 2 -> IDLE, count=2. Then start -> count=reload_reg=7.
- Async reset mid-run: drop resetn between clock edges while count=2 -> count=15, busy=0, tc=0 before the next rising edge.
